// File: rtl/ifetch_mem_responder.sv
// ifetch_mem_responder: fetch-side instruction supplier backed by a one-entry tagged word buffer.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   PCF                fetch PC (bits [1:0] ignored)
//   FlushI             one-cycle buffer invalidate (fence.i)
//   Instr, IStall      instruction for PCF / high while Instr is not valid
//   mem_valid/addr     word read request, held until mem_ready
//   mem_ready/rdata    one-cycle response strobe with read data
//   MissCount          completed memory reads, wrapping
module ifetch_mem_responder #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          PCF,
    input  logic                 FlushI,
    output logic [31:0]          Instr,
    output logic                 IStall,
    output logic                 mem_valid,
    output logic [31:0]          mem_addr,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata,
    output logic [CNT_WIDTH-1:0] MissCount
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t               state_q, state_d;
    logic [31:0]          req_addr_q, req_addr_d;
    logic                 buf_valid_q, buf_valid_d;
    logic [29:0]          buf_addr_q, buf_addr_d;
    logic [31:0]          buf_data_q, buf_data_d;
    logic                 drop_q, drop_d;
    logic [CNT_WIDTH-1:0] miss_q, miss_d;
    logic                 hit;
    logic                 unused_pc_bits;
    assign unused_pc_bits = ^PCF[1:0];
    assign hit       = buf_valid_q && (buf_addr_q == PCF[31:2]);
    assign Instr     = hit ? buf_data_q : NOP_INSTR;
    assign IStall    = !hit;
    assign mem_valid = state_q == REQ;
    assign mem_addr  = req_addr_q;
    assign MissCount = miss_q;
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        drop_d      = drop_q;
        miss_d      = miss_q;
        if (state_q == IDLE) begin
            if (!hit && !FlushI) begin
                req_addr_d = {PCF[31:2], 2'b00};
                state_d    = REQ;
            end
        end else if (mem_ready) begin
            state_d = IDLE;
            miss_d  = miss_q + CNT_WIDTH'(1);
            // a completion that overlaps or follows a flush carries stale data
            drop_d  = 1'b0;
            if (!drop_q && !FlushI) begin
                buf_data_d  = mem_rdata;
                buf_addr_d  = req_addr_q[31:2];
                buf_valid_d = 1'b1;
            end
        end else if (FlushI) begin
            drop_d = 1'b1;
        end
        if (FlushI) buf_valid_d = 1'b0;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= NOP_INSTR;
            drop_q      <= 1'b0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            drop_q      <= drop_d;
            miss_q      <= miss_d;
        end
    end
endmodule

// File: tb/tb_ifetch_mem_responder.sv
// tb_ifetch_mem_responder: self-checking bench with a wait-state memory model and an address scoreboard.
module tb_ifetch_mem_responder;
    localparam int CW = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   PCF = '0;
    logic          FlushI = 1'b0;
    logic [31:0]   Instr;
    logic          IStall;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic [CW-1:0] MissCount;
    int            ws = 0;
    bit            stray = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [31:0]   sbq[$];
    logic [CW-1:0] exp_miss = '0;
    ifetch_mem_responder #(.NOP_INSTR(NOP), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn), .PCF(PCF), .FlushI(FlushI),
        .Instr(Instr), .IStall(IStall), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .MissCount(MissCount)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0297 : {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // memory model: answers after ws wait cycles; stray forces a strobe with no request
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (stray) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end else if (mem_valid) begin
                if (cnt >= ws) begin
                    mem_ready = 1'b1;
                    mem_rdata = data_of(mem_addr);
                    cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end
    // scoreboard: every completed handshake must match the next expected address
    initial forever begin
        @(negedge clk);
        #2;
        if (resetn && mem_valid && mem_ready) begin
            if (sbq.size() == 0) check("sb_unexpected_req", mem_addr, 32'hFFFF_FFFF);
            else check("sb_req_addr", mem_addr, sbq.pop_front());
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    task automatic wait_hit(input logic [31:0] ea, output int n, output int v, output int bad);
        n = 0; v = 0; bad = 0;
        while (IStall !== 1'b0 && n < 40) begin
            if (mem_valid) begin
                v++;
                if (mem_addr !== ea) bad++;
            end
            @(negedge clk);
            #1;
            n++;
        end
    endtask
    task automatic fetch(input logic [31:0] pc, input int w, input bit miss, input int cyc);
        int n, v, bad;
        logic [31:0] a;
        a = {pc[31:2], 2'b00};
        @(negedge clk);
        ws = w;
        PCF = pc;
        if (miss) begin
            sbq.push_back(a);
            exp_miss++;
        end
        #1;
        wait_hit(a, n, v, bad);
        check("stall_cycles", n, cyc);
        check("valid_cycles", v, miss ? w + 1 : 0);
        check("addr_stable", bad, 0);
        check("instr", Instr, data_of(a));
        check("miss_count", 32'(MissCount), 32'(exp_miss));
    endtask
    task automatic flush_seq(input logic [31:0] pc, input int w, input int dly, input int cyc);
        int n, v, bad;
        @(negedge clk);
        ws = w;
        PCF = pc;
        sbq.push_back(pc);
        sbq.push_back(pc);
        exp_miss += 2;
        @(negedge clk);
        repeat (dly) @(negedge clk);
        FlushI = 1'b1;
        @(negedge clk);
        FlushI = 1'b0;
        #1;
        check("flush_stall", 32'(IStall), 1);
        wait_hit(pc, n, v, bad);
        check("flush_cycles", n, cyc);
        check("flush_instr", Instr, data_of(pc));
        check("flush_miss_count", 32'(MissCount), 32'(exp_miss));
    endtask
    typedef struct {
        logic [31:0] pc;
        int          w;
        bit          miss;
        int          cyc;
    } vec_t;
    vec_t tbl[8];
    initial begin
        int n, v, bad;
        logic [CW-1:0] start;
        tbl[0] = '{32'h0000_0100, 0, 1'b1, 2};
        tbl[1] = '{32'h0000_0104, 3, 1'b1, 5};
        tbl[2] = '{32'h0000_0106, 0, 1'b0, 0};
        tbl[3] = '{32'h0000_0503, 0, 1'b1, 2};
        tbl[4] = '{32'h0000_0500, 0, 1'b0, 0};
        tbl[5] = '{32'h0000_0508, 1, 1'b1, 3};
        tbl[6] = '{32'h0000_050C, 2, 1'b1, 4};
        tbl[7] = '{32'h0000_0104, 0, 1'b1, 2};
        repeat (3) @(negedge clk);
        #1;
        check("rst_instr", Instr, NOP);
        check("rst_istall", 32'(IStall), 1);
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_miss_count", 32'(MissCount), 0);
        // first fetch straight out of reset
        @(negedge clk);
        resetn = 1'b1;
        sbq.push_back(32'h0);
        exp_miss = 1;
        #1;
        wait_hit(32'h0, n, v, bad);
        check("first_stall_cycles", n, 2);
        check("first_instr", Instr, 32'h0000_0297);
        check("first_miss_count", 32'(MissCount), 1);
        foreach (tbl[i]) fetch(tbl[i].pc, tbl[i].w, tbl[i].miss, tbl[i].cyc);
        // held PC reuses the buffer
        fetch(32'h100, 0, 1'b1, 2);
        v = 0; bad = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (mem_valid) v++;
            if (Instr !== data_of(32'h100) || IStall !== 1'b0) bad++;
        end
        check("reuse_valid", v, 0);
        check("reuse_instr", bad, 0);
        check("reuse_miss_count", 32'(MissCount), 32'(exp_miss));
        // strobe with no request outstanding
        @(negedge clk);
        #3 stray = 1'b1;
        @(negedge clk);
        #3 stray = 1'b0;
        @(negedge clk);
        #1;
        check("stray_instr", Instr, data_of(32'h100));
        check("stray_miss_count", 32'(MissCount), 32'(exp_miss));
        // redirect while a request is pending
        @(negedge clk);
        ws = 3;
        PCF = 32'h200;
        sbq.push_back(32'h200);
        sbq.push_back(32'h300);
        exp_miss += 2;
        @(negedge clk);
        #1;
        check("redir_pending", 32'(mem_valid), 1);
        PCF = 32'h300;
        #1;
        wait_hit(32'h300, n, v, bad);
        check("redir_cycles", n, 9);
        check("redir_valid_cycles", v, 8);
        check("redir_instr", Instr, data_of(32'h300));
        check("redir_miss_count", 32'(MissCount), 32'(exp_miss));
        // flush coinciding with mem_ready, then flush mid-request
        flush_seq(32'h400, 0, 0, 2);
        flush_seq(32'h700, 3, 1, 7);
        fetch(32'h400, 0, 1'b1, 2);
        // flush in IDLE: invalidates, then blocks the request for one cycle
        @(negedge clk);
        ws = 0;
        FlushI = 1'b1;
        #1;
        check("fidle_hit_before", 32'(IStall), 0);
        @(negedge clk);
        #1;
        check("fidle_inval", 32'(IStall), 1);
        @(negedge clk);
        FlushI = 1'b0;
        sbq.push_back(32'h400);
        exp_miss++;
        #1;
        check("fidle_block", 32'(mem_valid), 0);
        wait_hit(32'h400, n, v, bad);
        check("fidle_cycles", n, 2);
        check("fidle_instr", Instr, data_of(32'h400));
        // reset in the middle of a request
        @(negedge clk);
        ws = 10;
        PCF = 32'h600;
        @(negedge clk);
        #1;
        check("rstmid_pending", 32'(mem_valid), 1);
        #2 resetn = 1'b0;
        #1;
        check("rstmid_mem_valid", 32'(mem_valid), 0);
        check("rstmid_istall", 32'(IStall), 1);
        check("rstmid_instr", Instr, NOP);
        check("rstmid_miss_count", 32'(MissCount), 0);
        @(negedge clk);
        ws = 0;
        resetn = 1'b1;
        sbq.push_back(32'h600);
        exp_miss = 1;
        #1;
        wait_hit(32'h600, n, v, bad);
        check("rstmid_refetch_cycles", n, 2);
        check("rstmid_refetch_instr", Instr, data_of(32'h600));
        // counter wrap
        start = exp_miss;
        for (int i = 0; i < 16; i++) fetch(32'h1000 + 32'(4 * i), 0, 1'b1, 2);
        check("wrap_miss_count", 32'(MissCount), 32'(start));
        repeat (2) @(negedge clk);
        check("sb_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
